// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared fetch payload types and constants
package cpuDefine;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } FetchData;

    typedef struct packed {
        logic       is_exc;
        logic [5:0] ecode;
    } FetchExc;

    // andi r0,r0,0 at pc 0: harmless if it ever reaches decode
    localparam FetchData NOP_FETCH = '{pc: 32'h0000_0000, inst: 32'h0340_0000};

    localparam logic [5:0] ADEF = 6'h08;
    localparam logic [5:0] TLBR = 6'h3F;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch-side and decode-side handshake bundle
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    import cpuDefine::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic             valid_in;
    FetchData         data_in;
    FetchExc          exc_in;
    logic             allow_out;
    logic             valid_out;
    FetchData         data_out;
    FetchExc          exc_out;
    logic             allow_in;
    logic [PTR_W:0]   count;

    modport master (
        output valid_in, data_in, exc_in, allow_in,
        input  allow_out, valid_out, data_out, exc_out, count
    );

    modport slave (
        input  valid_in, data_in, exc_in, allow_in,
        output allow_out, valid_out, data_out, exc_out, count
    );

endinterface

// File: rtl/inst_fetch_queue_ptr_ctrl.sv
// rtl/inst_fetch_queue_ptr_ctrl.sv - circular pointers, occupancy and full/empty
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - elastic IF->ID instruction buffer with exception lock
module inst_fetch_queue
    import cpuDefine::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              flush,
    inst_fetch_queue_if.slave fq
);

    localparam logic [0:0] OPEN   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    FetchData data_mem [DEPTH];
    FetchExc  exc_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             allow;
    logic [0:0]       lock_state;

    // allow depends only on registered state; a pop never frees a slot same-cycle
    assign allow = !full && (lock_state == OPEN);
    assign push  = fq.valid_in && allow && !areset;
    assign pop   = !empty && fq.allow_in;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk    (aclk),
        .rst    (areset),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge aclk) begin
        if (push) begin
            data_mem[wr_ptr] <= fq.data_in;
            exc_mem[wr_ptr]  <= fq.exc_in;
        end
    end

    // The excepting entry is kept; nothing behind it is accepted until redirect
    always_ff @(posedge aclk) begin
        if (areset || flush) begin
            lock_state <= OPEN;
        end else if (lock_state == OPEN && push && fq.exc_in.is_exc) begin
            lock_state <= LOCKED;
        end
    end

    assign fq.allow_out = allow;
    assign fq.valid_out = !empty;
    assign fq.data_out  = empty ? NOP_FETCH : data_mem[rd_ptr];
    assign fq.exc_out   = empty ? FetchExc'('0) : exc_mem[rd_ptr];
    assign fq.count     = count;

endmodule
